// File: rtl/lc3_pkg.sv
// Shared LC3 definitions: opcode constants, memory FSM state encoding and
// small opcode classification helpers used by the pipeline controller.
package lc3_pkg;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  typedef enum logic [1:0] {
    MEM_READ  = 2'b00,
    MEM_IND   = 2'b01,
    MEM_WRITE = 2'b10,
    MEM_IDLE  = 2'b11
  } mem_state_t;

  // True for the instructions whose result comes straight out of the ALU.
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
  endfunction

endpackage

// File: rtl/lc3_mem_fsm.sv
// Memory-access sequencer for LD/LDR/LDI/ST/STR/STI. Exposes both the current
// state and the next state so the controller can register its stage enables
// in step with the stall.
module lc3_mem_fsm
  import lc3_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       enable_execute,
  input  logic       complete_data,
  output mem_state_t mem_state,
  output mem_state_t mem_state_next
);

  mem_state_t state_reg, state_next;
  // Remembers whether an indirect access finishes as a store (STI) or a load
  // (LDI); ir_exec may move on while the access is in flight.
  logic ind_store_reg, ind_store_next;

  // State register; reset drops any in-flight access immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= MEM_IDLE;
      ind_store_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ind_store_reg <= ind_store_next;
    end
  end

  // Next-state logic: launch from IDLE on a memory opcode in execute, advance
  // only when the data memory reports completion.
  always_comb begin
    state_next     = state_reg;
    ind_store_next = ind_store_reg;
    case (state_reg)
      MEM_IDLE: begin
        if (enable_execute) begin
          case (opcode)
            OP_LD, OP_LDR: state_next = MEM_READ;
            OP_ST, OP_STR: state_next = MEM_WRITE;
            OP_LDI: begin
              state_next     = MEM_IND;
              ind_store_next = 1'b0;
            end
            OP_STI: begin
              state_next     = MEM_IND;
              ind_store_next = 1'b1;
            end
            default: state_next = MEM_IDLE;
          endcase
        end
      end
      MEM_IND: begin
        if (complete_data) state_next = ind_store_reg ? MEM_WRITE : MEM_READ;
      end
      MEM_READ, MEM_WRITE: begin
        if (complete_data) state_next = MEM_IDLE;
      end
      default: state_next = MEM_IDLE;
    endcase
  end

  assign mem_state      = state_reg;
  assign mem_state_next = state_next;

endmodule

// File: rtl/lc3_pipeline_controller.sv
// Central sequencer for the five-stage LC3 pipeline: pipeline fill after
// reset, memory stalls, branch/jump bubbles and ALU bypass detection.
module lc3_pipeline_controller
  import lc3_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        complete_instr,
  input  logic        complete_data,
  input  logic [15:0] ir,
  input  logic [15:0] ir_exec,
  input  logic [2:0]  nzp,
  output logic        enable_fetch,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic        enable_updatepc,
  output logic        br_taken,
  output logic        bypass_alu_1,
  output logic        bypass_alu_2,
  output logic [1:0]  mem_state
);

  logic [1:0] fill_reg, fill_next;
  logic [1:0] bubble_reg, bubble_next;
  logic       fetch_reg, decode_reg, execute_reg, writeback_reg, updatepc_reg, br_taken_reg;
  logic       fetch_next, decode_next, execute_next, writeback_next, updatepc_next, br_taken_next;

  mem_state_t mem_cur, mem_nxt;
  logic       busy, busy_next;
  logic [3:0] op_dec, op_exec;
  logic       branch_in_decode;
  logic       branch_cond;
  logic       src1_reads_reg, src2_reads_reg;

  // Fields of ir/ir_exec the controller never looks at.
  logic       unused_bits;
  assign unused_bits = ^{ir[11:9], ir[4:3], ir_exec[8:0]};

  lc3_mem_fsm u_mem_fsm (
    .clk            (clk),
    .rst            (rst),
    .opcode         (op_exec),
    .enable_execute (execute_reg),
    .complete_data  (complete_data),
    .mem_state      (mem_cur),
    .mem_state_next (mem_nxt)
  );

  assign op_dec    = ir[15:12];
  assign op_exec   = ir_exec[15:12];
  assign busy      = (mem_cur != MEM_IDLE);
  assign busy_next = (mem_nxt != MEM_IDLE);

  // Front-end enables stall whenever instruction memory has not delivered.
  logic [2:0] front_reg, front_gated;
  assign front_reg = {fetch_reg, decode_reg, updatepc_reg};
  for (genvar gi = 0; gi < 3; gi++) begin : g_front_gate
    assign front_gated[gi] = front_reg[gi] & complete_instr;
  end
  assign enable_fetch    = front_gated[2];
  assign enable_decode   = front_gated[1];
  assign enable_updatepc = front_gated[0];
  assign enable_execute  = execute_reg;
  // During a stall writeback only fires as the final load data arrives.
  assign enable_writeback = busy ? ((mem_cur == MEM_READ) && complete_data) : writeback_reg;
  assign br_taken         = br_taken_reg;
  assign mem_state        = mem_cur;

  assign branch_in_decode = enable_decode && ((op_dec == OP_BR) || (op_dec == OP_JMP));
  assign branch_cond      = (op_exec == OP_JMP) || ((ir_exec[11:9] & nzp) != 3'b000);

  // Bypass detection: which decode-stage instructions read SR1 / SR2.
  assign src1_reads_reg = is_alu_op(op_dec) || (op_dec == OP_LDR) ||
                          (op_dec == OP_STR) || (op_dec == OP_JMP);
  assign src2_reads_reg = ((op_dec == OP_ADD) || (op_dec == OP_AND)) && !ir[5];

  // Combinational bypass flags, valid alongside ir/ir_exec.
  always_comb begin
    bypass_alu_1 = 1'b0;
    bypass_alu_2 = 1'b0;
    if (execute_reg && is_alu_op(op_exec)) begin
      bypass_alu_1 = (ir_exec[11:9] == ir[8:6]) && src1_reads_reg;
      bypass_alu_2 = (ir_exec[11:9] == ir[2:0]) && src2_reads_reg;
    end
  end

  // Next values for counters and registered enables; enables are derived from
  // the next stall/bubble state so they line up with the cycles they govern.
  always_comb begin
    fill_next = (fill_reg == 2'd3) ? 2'd3 : fill_reg + 2'd1;

    if (branch_in_decode)
      bubble_next = 2'd3;
    else if (busy)
      bubble_next = bubble_reg;
    else if (bubble_reg != 2'd0)
      bubble_next = bubble_reg - 2'd1;
    else
      bubble_next = bubble_reg;

    fetch_next     = !busy_next && (bubble_next == 2'd0);
    decode_next    = (fill_reg >= 2'd1) && !busy_next && (bubble_next == 2'd0);
    execute_next   = (fill_reg >= 2'd2) && !busy_next;
    writeback_next = (fill_reg == 2'd3);
    updatepc_next  = !busy_next && (bubble_next <= 2'd1);
    br_taken_next  = !busy_next && (bubble_next == 2'd1) && branch_cond;
  end

  // Controller state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_reg      <= 2'd0;
      bubble_reg    <= 2'd0;
      fetch_reg     <= 1'b0;
      decode_reg    <= 1'b0;
      execute_reg   <= 1'b0;
      writeback_reg <= 1'b0;
      updatepc_reg  <= 1'b0;
      br_taken_reg  <= 1'b0;
    end else begin
      fill_reg      <= fill_next;
      bubble_reg    <= bubble_next;
      fetch_reg     <= fetch_next;
      decode_reg    <= decode_next;
      execute_reg   <= execute_next;
      writeback_reg <= writeback_next;
      updatepc_reg  <= updatepc_next;
      br_taken_reg  <= br_taken_next;
    end
  end

endmodule

// File: tb/tb_lc3_pipeline_controller.sv
// Scoreboard bench for lc3_pipeline_controller: a driver issues one input set
// per cycle, predicts the outputs from a behavioural model and queues them; a
// monitor pops and compares against the DUT each cycle.
module tb_lc3_pipeline_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        complete_instr = 1'b0;
  logic        complete_data = 1'b0;
  logic [15:0] ir = 16'hE000;
  logic [15:0] ir_exec = 16'hE000;
  logic [2:0]  nzp = 3'b010;
  logic        enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatepc;
  logic        br_taken, bypass_alu_1, bypass_alu_2;
  logic [1:0]  mem_state;

  lc3_pipeline_controller dut (
    .clk              (clk),
    .rst              (rst),
    .complete_instr   (complete_instr),
    .complete_data    (complete_data),
    .ir               (ir),
    .ir_exec          (ir_exec),
    .nzp              (nzp),
    .enable_fetch     (enable_fetch),
    .enable_decode    (enable_decode),
    .enable_execute   (enable_execute),
    .enable_writeback (enable_writeback),
    .enable_updatepc  (enable_updatepc),
    .br_taken         (br_taken),
    .bypass_alu_1     (bypass_alu_1),
    .bypass_alu_2     (bypass_alu_2),
    .mem_state        (mem_state)
  );

  always #5 clk = ~clk;

  localparam logic [15:0] NOP = 16'hE000; // LEA: no memory, no bubble, no bypass

  typedef struct packed {
    logic [4:0] en;  // fetch, decode, execute, writeback, updatepc
    logic       br;
    logic [1:0] bp;  // bypass_alu_1, bypass_alu_2
    logic [1:0] ms;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   done = 1'b0;

  // Behavioural model state
  int         edges_since_reset = 0; // saturates at 4
  int         bubbles_left = 0;
  logic [1:0] access_q[$];           // remaining memory accesses, front = current
  bit         br_pending = 1'b0;

  task automatic cycle(input logic r, input logic [15:0] i_ir, input logic [15:0] i_ex,
                       input logic [2:0] i_nzp, input logic ci, input logic cd);
    exp_t e;
    bit busy, ex, fe, de, up, wb, alu_ex;
    logic [3:0] dop, xop;
    @(negedge clk);
    rst = r; ir = i_ir; ir_exec = i_ex; nzp = i_nzp; complete_instr = ci; complete_data = cd;
    dop = i_ir[15:12];
    xop = i_ex[15:12];
    if (r) begin
      edges_since_reset = 0;
      bubbles_left = 0;
      access_q.delete();
      br_pending = 1'b0;
      e = '{en: 5'b0, br: 1'b0, bp: 2'b0, ms: 2'b11};
      exp_q.push_back(e);
      return;
    end
    busy   = access_q.size() > 0;
    ex     = (edges_since_reset >= 3) && !busy;
    fe     = (edges_since_reset >= 1) && !busy && bubbles_left == 0 && ci;
    de     = (edges_since_reset >= 2) && !busy && bubbles_left == 0 && ci;
    up     = (edges_since_reset >= 1) && !busy && bubbles_left <= 1 && ci;
    wb     = busy ? (access_q[0] == 2'b00 && cd) : (edges_since_reset >= 4);
    alu_ex = xop inside {4'd1, 4'd5, 4'd9};
    e.en = {fe, de, ex, wb, up};
    e.br = br_pending;
    e.bp[1] = ex && alu_ex && (i_ex[11:9] == i_ir[8:6]) &&
              (dop inside {4'd1, 4'd5, 4'd9, 4'd6, 4'd7, 4'd12});
    e.bp[0] = ex && alu_ex && (i_ex[11:9] == i_ir[2:0]) &&
              (dop inside {4'd1, 4'd5}) && !i_ir[5];
    e.ms = busy ? access_q[0] : 2'b11;
    exp_q.push_back(e);
    // Advance the model across the coming clock edge.
    if (busy) begin
      if (cd) void'(access_q.pop_front());
    end else if (ex) begin
      case (xop)
        4'd2, 4'd6:  access_q.push_back(2'b00);
        4'd3, 4'd7:  access_q.push_back(2'b10);
        4'd10: begin access_q.push_back(2'b01); access_q.push_back(2'b00); end
        4'd11: begin access_q.push_back(2'b01); access_q.push_back(2'b10); end
        default: ;
      endcase
    end
    if (de && (dop == 4'd0 || dop == 4'd12)) bubbles_left = 3;
    else if (!busy && bubbles_left > 0) bubbles_left--;
    if (edges_since_reset < 4) edges_since_reset++;
    br_pending = (access_q.size() == 0) && (bubbles_left == 1) &&
                 (xop == 4'd12 || (i_ex[11:9] & i_nzp) != 3'b000);
  endtask

  // Driver: directed scenarios followed by randomized traffic.
  initial begin
    logic [15:0] r_ir, r_ex;
    logic [2:0]  r_nzp;
    // Reset and pipeline fill
    repeat (2) cycle(1, NOP, NOP, 3'b010, 1, 0);
    repeat (6) cycle(0, NOP, NOP, 3'b010, 1, 0);
    // LDI: indirect then read, completions two cycles apart
    cycle(0, NOP, 16'hA201, 3'b010, 1, 0);
    cycle(0, NOP, NOP, 3'b010, 1, 0);
    cycle(0, NOP, NOP, 3'b010, 1, 1);
    cycle(0, NOP, NOP, 3'b010, 1, 0);
    cycle(0, NOP, NOP, 3'b010, 1, 1);
    repeat (2) cycle(0, NOP, NOP, 3'b010, 1, 0);
    // BRz taken, then not taken
    cycle(0, 16'h0403, NOP, 3'b010, 1, 0);
    repeat (5) cycle(0, NOP, 16'h0403, 3'b010, 1, 0);
    cycle(0, 16'h0403, NOP, 3'b001, 1, 0);
    repeat (5) cycle(0, NOP, 16'h0403, 3'b001, 1, 0);
    // Bypass: register AND, then immediate AND
    cycle(0, 16'h5841, 16'h1283, 3'b010, 1, 0);
    cycle(0, 16'h5861, 16'h1283, 3'b010, 1, 0);
    // STR with long data wait
    cycle(0, NOP, 16'h7245, 3'b010, 1, 0);
    repeat (5) cycle(0, NOP, NOP, 3'b010, 1, 0);
    cycle(0, NOP, NOP, 3'b010, 1, 1);
    repeat (2) cycle(0, NOP, NOP, 3'b010, 1, 0);
    // STR interrupted by reset
    cycle(0, NOP, 16'h7245, 3'b010, 1, 0);
    repeat (2) cycle(0, NOP, NOP, 3'b010, 1, 0);
    repeat (2) cycle(1, NOP, NOP, 3'b010, 1, 0);
    repeat (6) cycle(0, NOP, NOP, 3'b010, 1, 0);
    // Branch decoded while a load launches: bubbles freeze until idle
    cycle(0, 16'h0E01, 16'h2001, 3'b100, 1, 0);
    cycle(0, NOP, 16'h0E01, 3'b100, 1, 0);
    cycle(0, NOP, 16'h0E01, 3'b100, 1, 0);
    cycle(0, NOP, 16'h0E01, 3'b100, 1, 1);
    repeat (5) cycle(0, NOP, 16'h0E01, 3'b100, 1, 0);
    // Branch waiting in decode during a load
    cycle(0, NOP, 16'h2001, 3'b100, 1, 0);
    cycle(0, 16'hC1C0, NOP, 3'b100, 1, 0);
    cycle(0, 16'hC1C0, NOP, 3'b100, 1, 1);
    cycle(0, 16'hC1C0, NOP, 3'b100, 1, 0);
    repeat (5) cycle(0, NOP, 16'hC1C0, 3'b000, 1, 0);
    // Fetch stall
    cycle(0, NOP, NOP, 3'b010, 0, 0);
    cycle(0, 16'h0E01, NOP, 3'b010, 0, 0);
    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      r_ir  = 16'($urandom);
      r_ex  = 16'($urandom);
      r_nzp = 3'($urandom);
      cycle(($urandom_range(0, 249) == 0), r_ir, r_ex, r_nzp,
            ($urandom_range(0, 9) != 0), 1'($urandom));
    end
    done = 1'b1;
  end

  // Monitor: compare each cycle's outputs against the queued prediction.
  initial begin
    exp_t e;
    logic [4:0] en_act;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() == 0) begin
        if (done) break;
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_empty cycle %0d: DUT output with no prediction queued", cyc);
      end else begin
        e = exp_q.pop_front();
        en_act = {enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatepc};
        n_checks++;
        if (en_act !== e.en) begin
          n_fail++;
          $display("FAIL enables cycle %0d: got %b expected %b", cyc, en_act, e.en);
        end
        n_checks++;
        if (br_taken !== e.br) begin
          n_fail++;
          $display("FAIL br_taken cycle %0d: got %b expected %b", cyc, br_taken, e.br);
        end
        n_checks++;
        if ({bypass_alu_1, bypass_alu_2} !== e.bp) begin
          n_fail++;
          $display("FAIL bypass cycle %0d: got %b expected %b", cyc,
                   {bypass_alu_1, bypass_alu_2}, e.bp);
        end
        n_checks++;
        if (mem_state !== e.ms) begin
          n_fail++;
          $display("FAIL mem_state cycle %0d: got %b expected %b", cyc, mem_state, e.ms);
        end
        $display("cycle %0d rst=%b ir=%h ir_exec=%h nzp=%b ci=%b cd=%b en=%b br=%b bp=%b ms=%b",
                 cyc, rst, ir, ir_exec, nzp, complete_instr, complete_data,
                 en_act, br_taken, {bypass_alu_1, bypass_alu_2}, mem_state);
      end
      cyc++;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Time limit in case the driver or monitor stops making progress.
  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, %0d checks, %0d failures", n_checks, n_fail);
    $fatal(1, "time limit reached");
  end

endmodule

// File: doc/lc3_pipeline_controller.md
# lc3_pipeline_controller

Central sequencer for the five-stage LC3 pipeline (fetch, decode, execute, writeback, memory). Generates per-stage enables, runs the memory-access state machine for LD/LDR/LDI/ST/STR/STI, inserts branch/jump bubbles, and flags ALU-result bypasses. Sits beside the datapath stages and gates their clock-enable inputs (including `enable_decode`).

## Interface
- No parameters. Opcode and `mem_state` encodings come from the shared package.
- `clk` in, 1: the single clock; all state updates on the rising edge.
- `rst` in, 1: asynchronous, active-high reset.
- `complete_instr` in, 1: instruction memory returned valid data this cycle.
- `complete_data` in, 1: data memory access finished this cycle.
- `ir` in, 16: decode-stage output instruction, next to enter execute.
- `ir_exec` in, 16: instruction currently in execute.
- `nzp` in, 3: architectural condition codes (PSR[2:0]).
- `enable_fetch`, `enable_decode`, `enable_execute`, `enable_writeback`, `enable_updatepc` out, 1 each: stage enables.
- `br_taken` out, 1: PC load selects branch/jump target.
- `bypass_alu_1`, `bypass_alu_2` out, 1 each: forward execute ALU result to SR1 / SR2.
- `mem_state` out, 2: 2'b00 READ, 2'b01 IND, 2'b10 WRITE, 2'b11 IDLE.

## Operation
- Reset values: all enables 0, `br_taken` 0, bypasses 0, `mem_state` IDLE, fill counter 0, bubble counter 0.
- Pipeline fill after reset release. A 2-bit fill counter goes 0→3 and saturates.
  - First clock: `enable_fetch` and `enable_updatepc` are 1.
  - Second clock: `enable_decode` is also 1.
  - Third clock: `enable_execute` is also 1.
  - Fourth clock onward: `enable_writeback` is also 1.
- Memory FSM:
  - Transitions out of IDLE occur only on a clock edge where `enable_execute` is 1 and `ir_exec[15:12]` is a memory opcode.
  - LD/LDR → READ. ST/STR → WRITE. LDI/STI → IND.
  - IND with `complete_data` → READ (LDI) or WRITE (STI).
  - READ or WRITE with `complete_data` → IDLE.
  - Without `complete_data`, the FSM holds its state.
- While `mem_state` ≠ IDLE: fetch, decode, execute and updatepc enables are 0.
  - `enable_writeback` is 1 only in the READ cycle where `complete_data` is 1; otherwise it is 0.
- Control hazard: when `ir[15:12]` is BR or JMP and `enable_decode` is 1, the 2-bit bubble counter loads 3.
  - While the counter ≠ 0: fetch, decode and updatepc enables are 0 and the counter decrements.
  - The counter does not decrement while `mem_state` ≠ IDLE.
  - In the cycle where the counter is 1: `enable_updatepc` is 1 and `br_taken` = (JMP) or ((`ir_exec[11:9]` & `nzp`) ≠ 0), registered as a one-cycle pulse.
  - A BR with nzp field 000 yields `br_taken` 0 and resumes at NPC.
- Fetch stall: `enable_fetch`, `enable_decode` and `enable_updatepc` are additionally gated by `complete_instr`.
- Bypass (combinational from `ir`/`ir_exec`):
  - `bypass_alu_1` = `ir_exec` is ADD/AND/NOT and `ir_exec[11:9]` == `ir[8:6]` and `ir` is ADD/AND/NOT/LDR/STR/JMP.
  - `bypass_alu_2` = `ir_exec` is ADD/AND/NOT and `ir_exec[11:9]` == `ir[2:0]` and `ir` is ADD/AND with `ir[5]` = 0.
  - Both bypasses are forced 0 while `enable_execute` is 0.
- Undefined opcodes cause no memory access, no bubbles, no bypass.

## Timing
- Enables, `br_taken` and `mem_state` are registered; bypasses are combinational, valid in the same cycle as `ir`/`ir_exec`.
- Memory stall latency: LD/ST = 1 + data wait cycles; LDI/STI = 2 accesses.
- `complete_data` in IDLE is ignored.
- Branch penalty: 3 bubble cycles.
- Simultaneous memory and branch events: the memory FSM has priority and the bubble counter freezes.
- `rst` asserted mid-access: FSM → IDLE immediately (asynchronous) and the fill sequence restarts on release.

## Structure
- `lc3_pkg` holds:
  - Opcode constants (BR, ADD, LD, ST, JMP, AND, LDR, STR, NOT, LDI, STI, LEA).
  - `mem_state` encodings.
  - An `is_alu_op` helper.
- `lc3_mem_fsm` is the one sub-module: the memory FSM, taking `ir_exec` opcode, `enable_execute`, `complete_data` and `rst`, and outputting `mem_state`.
- The top level keeps the fill counter, bubble counter and bypass logic.

## Test plan
- Reset release with `complete_instr`=1 → fetch/updatepc 1 at cycle 1, decode at 2, execute at 3, writeback at 4; `mem_state`=11 throughout.
- LDI (0xA201) in execute, `complete_data` at cycles +2 and +4 → `mem_state` 01→00→11; fetch disabled all stall cycles; writeback pulse only on the final READ completion.
- BRz (0x0403) with `nzp`=010 → 3 bubbles, `br_taken`=1 for exactly one cycle with updatepc 1. Same instruction with `nzp`=001 → `br_taken`=0.
- `ir_exec`=ADD R1,R2,R3 (0x1283), `ir`=AND R4,R1,R1 (0x5841) → `bypass_alu_1`=1, `bypass_alu_2`=1. Change `ir` to AND immediate 0x5861 → `bypass_alu_2`=0.
- STR in execute, `complete_data` held low 5 cycles then pulsed → WRITE held 5 cycles, then IDLE. Assert `rst` mid-WRITE in a second run → immediate IDLE, all enables 0.
- BR in decode while memory FSM is busy → bubble counter frozen until IDLE, then 3 bubbles complete.
